// File: rtl/packet_buffer_pkg.sv
// Shared definitions for the packet buffer read/write engines.
// Default geometry matches the writer side so both ends agree on packet layout.
package packet_buffer_pkg;

    localparam int DEF_MEM_SIZE   = 1024;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_PKT_WORDS  = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } reader_state_e;

endpackage

// File: rtl/reader_skid_fifo.sv
// Two-entry first-word-fall-through FIFO between the buffer read port and egress.
// The head entry is visible on dout whenever count is non-zero.
module reader_skid_fifo
    import packet_buffer_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_WIDTH + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_pop;

    always_comb begin
        do_pop   = pop && (count_q != 2'd0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/packet_buffer_reader.sv
// Streams one fixed-length packet out of the packet buffer per start request,
// hiding the memory's one-cycle read latency behind a credit-checked skid FIFO.
module packet_buffer_reader
    import packet_buffer_pkg::*;
#(
    parameter  int MEM_SIZE   = DEF_MEM_SIZE,
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int PKT_WORDS  = DEF_PKT_WORDS,
    localparam int ADDR_W     = $clog2(MEM_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     start_addr,
    output logic                  busy,
    output logic [ADDR_W-1:0]     ra,
    input  logic [DATA_WIDTH-1:0] q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  done
);

    localparam int CNT_W = $clog2(PKT_WORDS + 1);

    reader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] ra_q, ra_d;
    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;

    logic [1:0]        fifo_count;
    logic [DATA_WIDTH:0] fifo_dout;
    logic              pop;
    logic [2:0]        occupancy;
    logic              issue;
    logic              issue_is_last;

    // ra_q doubles as the read pointer: it always holds the next address to issue.
    assign pop           = out_valid && out_ready;
    assign occupancy     = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
    assign issue_is_last = (issue_cnt_q == CNT_W'(PKT_WORDS - 1));
    assign issue         = (state_q == ISSUE) && (issue_cnt_q < CNT_W'(PKT_WORDS))
                           && (occupancy < 3'd2);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            ra_q            <= '0;
            issue_cnt_q     <= '0;
            beat_cnt_q      <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            ra_q            <= ra_d;
            issue_cnt_q     <= issue_cnt_d;
            beat_cnt_q      <= beat_cnt_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ISSUE;
            ISSUE:   if (issue && issue_is_last) state_d = DRAIN;
            DRAIN:   if (beat_cnt_q == CNT_W'(PKT_WORDS)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ra_d            = ra_q;
        issue_cnt_d     = issue_cnt_q;
        beat_cnt_d      = beat_cnt_q;
        inflight_d      = issue;
        inflight_last_d = issue && issue_is_last;
        if (state_q == IDLE && start) begin
            ra_d        = start_addr;
            issue_cnt_d = '0;
            beat_cnt_d  = '0;
        end
        if (issue) begin
            ra_d        = (ra_q == ADDR_W'(MEM_SIZE - 1)) ? '0 : ra_q + ADDR_W'(1);
            issue_cnt_d = issue_cnt_q + CNT_W'(1);
        end
        if (pop) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DRAIN) && (beat_cnt_q == CNT_W'(PKT_WORDS));
    end

    reader_skid_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (inflight_q),
        .pop     (pop),
        .din     ({inflight_last_q, q}),
        .dout    (fifo_dout),
        .count   (fifo_count)
    );

    assign ra        = ra_q;
    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = fifo_dout[DATA_WIDTH-1:0];
    assign out_last  = fifo_dout[DATA_WIDTH];

endmodule

// File: tb/tb_packet_buffer_reader.sv
// Scoreboard bench: three reader builds (16-, 4- and 1-word packets) on memories holding mem[i]=i.
// Expected beats are generated from packet rules when a start is accepted; a negedge monitor checks.
module tb_packet_buffer_reader;

    localparam int MEM = 1024;
    localparam int DW  = 32;
    localparam int AW  = 10;
    localparam int NI  = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start [NI];
    logic [AW-1:0] sa    [NI];
    logic          busy  [NI];
    logic [AW-1:0] ra    [NI];
    logic [DW-1:0] q     [NI];
    logic [DW-1:0] od    [NI];
    logic          ov    [NI];
    logic          ol    [NI];
    logic          dn    [NI];
    logic          rdy   [NI];

    int unsigned cyc = 0;
    int checks = 0;
    int errors = 0;

    // monitor-owned model state
    logic [DW:0] exp_q [NI][$];
    bit          mbusy    [NI];
    bit          dexp     [NI];
    bit          hold     [NI];
    bit          post_rst [NI];
    logic [DW:0] prev     [NI];
    int          acc_seen [NI];
    int          beats    [NI];
    int          to_seen = 0;
    bit          fin_done = 1'b0;

    // stimulus-owned state
    int          acc_cnt  [NI];
    logic [AW-1:0] req_addr [NI];
    int unsigned acc_cyc  [NI];
    bit          fr       [NI];
    bit          rand_en = 1'b0;
    int          to_cnt = 0;
    bit          fin_req = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) q[k] <= DW'(ra[k]);
    end

    packet_buffer_reader #(.MEM_SIZE(MEM), .DATA_WIDTH(DW), .PKT_WORDS(16)) u16 (
        .clk(clk), .reset_n(reset_n), .start(start[0]), .start_addr(sa[0]), .busy(busy[0]),
        .ra(ra[0]), .q(q[0]), .out_data(od[0]), .out_valid(ov[0]), .out_ready(rdy[0]),
        .out_last(ol[0]), .done(dn[0]));

    packet_buffer_reader #(.MEM_SIZE(MEM), .DATA_WIDTH(DW), .PKT_WORDS(4)) u4 (
        .clk(clk), .reset_n(reset_n), .start(start[1]), .start_addr(sa[1]), .busy(busy[1]),
        .ra(ra[1]), .q(q[1]), .out_data(od[1]), .out_valid(ov[1]), .out_ready(rdy[1]),
        .out_last(ol[1]), .done(dn[1]));

    packet_buffer_reader #(.MEM_SIZE(MEM), .DATA_WIDTH(DW), .PKT_WORDS(1)) u1 (
        .clk(clk), .reset_n(reset_n), .start(start[2]), .start_addr(sa[2]), .busy(busy[2]),
        .ra(ra[2]), .q(q[2]), .out_data(od[2]), .out_valid(ov[2]), .out_ready(rdy[2]),
        .out_last(ol[2]), .done(dn[2]));

    function automatic int pw(input int k);
        case (k)
            0:       return 16;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s inst%0d cyc=%0d actual=%0h required=%0h", name, k, cyc, act, expv);
        end
    endtask

    initial begin
        for (int k = 0; k < NI; k++) rdy[k] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < NI; k++) rdy[k] = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            bit nb;
            bit nd;
            logic [DW:0] e;
            if (!reset_n) begin
                exp_q[k].delete();
                mbusy[k]    = 1'b0;
                dexp[k]     = 1'b0;
                hold[k]     = 1'b0;
                post_rst[k] = 1'b1;
                acc_seen[k] = acc_cnt[k];
                beats[k]    = 0;
                continue;
            end
            if (post_rst[k]) begin
                chk("reset_valid", k, 64'(ov[k]), 64'd0);
                chk("reset_ra", k, 64'(ra[k]), 64'd0);
                post_rst[k] = 1'b0;
            end
            chk("busy", k, 64'(busy[k]), 64'(mbusy[k]));
            chk("done", k, 64'(dn[k]), 64'(dexp[k]));
            if (hold[k]) begin
                chk("hold_valid", k, 64'(ov[k]), 64'd1);
                chk("hold_beat", k, 64'({ol[k], od[k]}), 64'(prev[k]));
            end
            nd = 1'b0;
            if (ov[k]) begin
                if (exp_q[k].size() == 0) begin
                    chk("spurious_beat", k, 64'(ov[k]), 64'd0);
                end else if (rdy[k]) begin
                    e = exp_q[k].pop_front();
                    chk("beat", k, 64'({ol[k], od[k]}), 64'(e));
                    beats[k]++;
                    if (e[DW]) begin
                        nd = 1'b1;
                        if (fr[k]) chk("latency", k, 64'(cyc - acc_cyc[k]), 64'(pw(k) + 2));
                    end
                end
            end
            hold[k] = ov[k] && !rdy[k];
            prev[k] = {ol[k], od[k]};
            nb = mbusy[k];
            if (dexp[k]) nb = 1'b0;
            if (acc_cnt[k] != acc_seen[k]) begin
                for (int w = 0; w < pw(k); w++)
                    exp_q[k].push_back({(w == pw(k) - 1), DW'((int'(req_addr[k]) + w) % MEM)});
                acc_seen[k] = acc_cnt[k];
                nb = 1'b1;
            end
            mbusy[k] = nb;
            dexp[k]  = nd;
        end
        if (to_cnt != to_seen) begin
            chk("timeout", 0, 64'(to_cnt - to_seen), 64'd0);
            to_seen = to_cnt;
        end
        if (fin_req && !fin_done) begin
            for (int k = 0; k < NI; k++) chk("leftover_beats", k, 64'(exp_q[k].size()), 64'd0);
            fin_done = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic try_start(input int k, input int addr, input bit full, output bit ok);
        ok       = !mbusy[k];
        start[k] = 1'b1;
        sa[k]    = AW'(addr);
        if (ok) begin
            req_addr[k] = AW'(addr);
            acc_cyc[k]  = cyc;
            fr[k]       = full;
            acc_cnt[k]++;
        end
        tick();
        start[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        for (int i = 0; i < 3000; i++) begin
            if (!mbusy[k] && exp_q[k].size() == 0 && acc_cnt[k] == acc_seen[k]) return;
            tick();
        end
        to_cnt++;
    endtask

    initial begin
        bit ok;
        int b0;
        for (int k = 0; k < NI; k++) begin
            start[k] = 1'b0;
            sa[k] = '0;
            acc_cnt[k] = 0;
            req_addr[k] = '0;
            acc_cyc[k] = 0;
            fr[k] = 1'b0;
        end
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (2) tick();

        // full-rate packets, including the address wrap and the single-word build
        try_start(0, 100, 1'b1, ok);
        try_start(1, 1022, 1'b1, ok);
        try_start(2, 7, 1'b1, ok);
        for (int k = 0; k < NI; k++) wait_idle(k);
        repeat (3) tick();

        // random backpressure on random base addresses
        rand_en = 1'b1;
        for (int it = 0; it < 4; it++) begin
            for (int k = 0; k < NI; k++) try_start(k, (it == 0) ? 1020 : int'($urandom_range(0, MEM - 1)), 1'b0, ok);
            for (int k = 0; k < NI; k++) wait_idle(k);
        end
        rand_en = 1'b0;
        repeat (4) tick();

        // start requests while busy, repeated every cycle until one is taken
        try_start(0, 40, 1'b1, ok);
        repeat (5) tick();
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) try_start(0, 500, 1'b1, ok);
        if (!ok) to_cnt++;
        wait_idle(0);
        repeat (3) tick();

        // reset in the middle of a packet, then a clean packet
        try_start(0, 250, 1'b1, ok);
        b0 = beats[0];
        for (int i = 0; i < 100 && beats[0] < b0 + 5; i++) tick();
        if (beats[0] < b0 + 5) to_cnt++;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (2) tick();
        try_start(0, 200, 1'b1, ok);
        wait_idle(0);
        repeat (3) tick();

        fin_req = 1'b1;
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/packet_buffer_reader.md
Name: packet_buffer_reader

Overview:
- Read-side engine for the switch's fixed-length packet buffer, which is a simple dual-port memory with a 1-cycle registered read.
- On a start request, it walks PKT_WORDS consecutive addresses from a base address, tracks the memory's read latency, and streams the words out on a valid/ready interface with a last marker.
- It sits between the packet buffer and the egress/output-port logic.

Parameters:
- MEM_SIZE, 1024, number of words in the attached buffer memory; ADDR_W = $clog2(MEM_SIZE).
- DATA_WIDTH, 32, bits per memory word and per output beat.
- PKT_WORDS, 16, words per fixed-length packet; legal range 1..MEM_SIZE.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset_n  input  1  synchronous active-low reset, sampled on the clk rising edge.
- start  input  1  one-cycle request to read one packet.
- start_addr  input  ADDR_W  base address of the packet; sampled when start is accepted.
- busy  output  1  high while a packet is in progress; start is ignored while busy=1.
- ra  output  ADDR_W  memory read address.
- q  input  DATA_WIDTH  memory read data, valid the cycle after the matching ra issue.
- out_data  output  DATA_WIDTH  packet word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts the beat when out_valid&&out_ready.
- out_last  output  1  marks the final word of the packet; qualified by out_valid.
- done  output  1  one-cycle pulse in the cycle after the last beat handshake.

Behaviour:
- Reset (reset_n=0 at an edge):
  - busy=0, out_valid=0, out_last=0, done=0, ra=0, state=IDLE.
  - The FIFO is emptied and any in-flight read is discarded.
  - A reset mid-packet aborts the packet with no done pulse.
- States:
  - IDLE: start=1 → ISSUE. Load rd_ptr=start_addr, issue_cnt=0, beat_cnt=0. busy goes 1 in the next cycle.
  - ISSUE: issue reads while issue_cnt<PKT_WORDS. When issue_cnt reaches PKT_WORDS → DRAIN.
  - DRAIN: wait until beat_cnt==PKT_WORDS, i.e. the last handshake has occurred, then → IDLE and pulse done for one cycle.
- Read issue:
  - A read is issued in a cycle when state==ISSUE and (fifo_count + inflight − pop_this_cycle) < 2.
  - ra is a registered output. An "issue" means ra=rd_ptr is presented to memory with inflight=1 for the next cycle, so q is captured into the FIFO one cycle later.
- Address arithmetic: rd_ptr increments modulo MEM_SIZE, so it wraps to 0 after MEM_SIZE−1. A packet starting at MEM_SIZE−2 with PKT_WORDS=4 reads MEM_SIZE−2, MEM_SIZE−1, 0, 1.
- Output FIFO:
  - 2 entries, first-word-fall-through.
  - out_valid = (fifo_count>0).
  - out_data and out_last come from the head entry; out_last is stored per entry and set when beat index == PKT_WORDS−1.
- Credit rule: the FIFO never overflows. The credit check guarantees room for every in-flight word.
- Throughput: with out_ready held high, one beat per cycle after the initial latency.
  - First out_valid appears 2 cycles after start is sampled (accept → issue → capture).
  - A packet finishes in PKT_WORDS+2 cycles from start to last beat.
- Backpressure: with out_ready low, out_valid/out_data/out_last hold stable and issue stalls once the credits are used up. No word is lost or duplicated.
- Simultaneous events:
  - A push and a pop in the same cycle leave fifo_count unchanged.
  - A start arriving in the same cycle as done is ignored, because busy is still 1. The next packet is accepted the following cycle.
- PKT_WORDS=1: a single beat with out_last=1.

Decomposition:
- Package packet_buffer_pkg:
  - typedef enum of reader states {IDLE, ISSUE, DRAIN}.
  - localparam defaults for MEM_SIZE, DATA_WIDTH, PKT_WORDS, shared with the writer side.
- One sub-module: reader_skid_fifo, a 2-entry FWFT FIFO with push/pop/count, parameterized on DATA_WIDTH+1 so it also carries the last bit.

Test Plan:
- Memory preloaded with mem[i]=i. start_addr=100, out_ready=1 → beats 100..115 on consecutive cycles, out_last only on 115, done pulses once, busy=0 afterward.
- Wrap: MEM_SIZE=1024, start_addr=1022, PKT_WORDS=4 → beats 1022, 1023, 0, 1 with ra sequence 1022, 1023, 0, 1.
- Backpressure: out_ready toggles 1,0,0,1,0,1… (random, seeded) → the exact 16-word sequence is delivered with no drop or duplicate, data is stable while out_valid&&!out_ready, and the FIFO never overflows.
- Start while busy: a second start with start_addr=500 arrives mid-packet → it is ignored, and only the first packet's 16 words appear. A start in the cycle after done is accepted and yields 500..515.
- Reset mid-packet: reset_n=0 for 1 cycle after beat 5 → out_valid=0, busy=0, done=0 the next cycle, no stale beats afterward. A new start=200 yields 200..215 cleanly.
- PKT_WORDS=1 build: start_addr=7 → a single beat of 7 with out_last=1, done in the next cycle.
